wb_pipe_regs: RTL and testbench
===============================

WB_PIPE_REGS -- requirements
Module: wb_pipe_regs

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset.
  - clk  in  1  rising-edge clock.
  - rst  in  1  asynchronous, active-low reset.
REQ-002 SHALL have these EX-side inputs.
  - ex_valid  in  1  EX entry is a real instruction.
  - ex_pc_wb_data, ex_ih_wb_data, ex_alu_answer, ex_mem_wdata  in  16 each  EX results.
  - ex_wb_addr  in  4  write-back register address.
  - ex_reg_op  in  3  000 NOP, 001 REG, 010 IH, 011 SP, 100 T.
  - ex_wb_data_op  in  3  000 NOP, 001 ALU, 010 MEM, 011 IH, 100 PC.
  - ex_mem_rd, ex_mem_wr  in  1 each  load / store.
  - flush  in  1  load a bubble instead of the EX entry.
REQ-003 SHALL have these load-use inputs.
  - id_reg1_addr, id_reg2_addr  in  4 each  ID source register addresses.
  - id_reg1_used, id_reg2_used  in  1 each  source register is read.
REQ-004 SHALL have this memory port.
  - mem_req, mem_we  out  1 each  request, write enable.
  - mem_addr, mem_wdata  out  16 each  address, store data.
  - mem_ack  in  1  request complete this cycle.
  - mem_rdata  in  16  load data, valid with mem_ack.
REQ-005 SHALL drive these forwarding outputs (EX/MEM register contents).
  - emo_pc_wb_data, emo_ih_wb_data, emo_alu_answer  out  16 each.
  - emo_wb_addr  out  4.
  - emo_reg_op, emo_wb_data_op  out  3 each.
REQ-006 SHALL drive these forwarding outputs (MEM/WB register contents).
  - mwo_pc_wb_data, mwo_ih_wb_data, mwo_alu_answer, mwo_ram_read_answer  out  16 each.
  - mwo_wb_addr  out  4.
  - mwo_reg_op, mwo_wb_data_op  out  3 each.
REQ-007 SHALL drive these control and write-back outputs.
  - stall_ex  out  1  upstream must hold.
  - load_use_stall  out  1  ID must hold one cycle.
  - wb_en  out  1  register file write enable.
  - wb_addr  out  4  register file write address.
  - wb_data  out  16  register file write data.
  - mem_wait_cycles  out  8  saturating wait counter.

Function
REQ-008 EX/MEM SHALL capture the EX entry on each edge with stall_ex=0: bubble if flush=1 or ex_valid=0, otherwise the entry. With stall_ex=1 it SHALL hold and flush SHALL be ignored.
REQ-009 Bubble SHALL mean: valid=0, reg_op=NOP, wb_data_op=NOP, rd/wr=0, all data fields 0.
REQ-010 mem_req SHALL be combinational and equal EX/MEM valid AND (rd OR wr).
  - mem_we = wr.
  - mem_addr = emo_alu_answer.
  - mem_wdata = the registered ex_mem_wdata.
REQ-011 stall_ex SHALL equal mem_req AND NOT mem_ack.
REQ-012 FSM states SHALL be IDLE and WAIT.
  - IDLE to WAIT: mem_req=1 and mem_ack=0.
  - WAIT to IDLE: mem_ack=1.
  - In WAIT, mem_req/we/addr/wdata SHALL stay constant.
REQ-013 mem_wait_cycles SHALL clear on each request's first cycle and increment per WAIT cycle, saturating at 255.
REQ-014 MEM/WB SHALL load a bubble on edges with stall_ex=1. Otherwise it SHALL load EX/MEM, with ram_read_answer = mem_rdata when rd=1, else 0.
REQ-015 Latency: entry accepted at edge N SHALL appear on emo_* in cycle N+1 and on mwo_*/wb_* in cycle N+2, plus one cycle per wait cycle.
REQ-016 wb_en SHALL be 1 iff mwo_reg_op != NOP. wb_addr SHALL be mwo_wb_addr.
REQ-017 wb_data SHALL select by mwo_wb_data_op: ALU→alu_answer, MEM→ram_read_answer, IH→ih_wb_data, PC→pc_wb_data, NOP or other→0.
REQ-018 load_use_stall SHALL be combinational: 1 iff emo_wb_data_op=MEM, emo_reg_op!=NOP, and (id_reg1_used and id_reg1_addr=emo_wb_addr, or id_reg2_used and id_reg2_addr=emo_wb_addr).
REQ-019 mem_ack in IDLE with mem_req=0 SHALL be ignored.

Reset
REQ-020 rst=0 SHALL, asynchronously:
  - load bubbles into both pipeline registers;
  - set state to IDLE and mem_wait_cycles to 0;
  - force all outputs to 0 (NOP encodings);
  - abandon any request in flight with no completion.

Verification
REQ-021 ALU op, ex_alu_answer=0x1234, wb_addr=3, reg_op=REG, op=ALU, accepted at edge 0 -> emo_alu_answer=0x1234 in cycle 1; wb_en=1, wb_addr=3, wb_data=0x1234 in cycle 2.
REQ-022 Load, addr 0x8000, mem_ack delayed 3 cycles, rdata=0xBEEF -> stall_ex=1 for 3 cycles; mem_addr steady at 0x8000; MEM/WB bubbles; mem_wait_cycles=3; then wb_data=0xBEEF.
REQ-023 Load to R2 in EX/MEM, id_reg1_addr=2, id_reg1_used=1 -> load_use_stall=1. With id_reg1_used=0 -> 0.
REQ-024 flush=1 with a valid ALU entry, stall_ex=0 -> emo_reg_op=NOP next cycle, wb_en=0 two cycles later. Same with stall_ex=1 -> EX/MEM unchanged.
REQ-025 rst=0 mid-WAIT -> mem_req=0, state IDLE, all outputs 0 immediately. A later mem_ack has no effect.
REQ-026 Store with zero-wait ack -> stall_ex=0, mem_we=1 for one cycle, wb_en=0.

Source files
------------

// File: rtl/wb_pipe_regs_if.sv
// Memory-side bus of the EX/MEM/WB pipeline: one request at a time,
// completion signalled by mem_ack with load data alongside it.
interface wb_pipe_regs_if;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ack;
    logic [15:0] mem_rdata;

    // Pipeline side issues requests
    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    // Memory side answers them
    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/wb_pipe_regs.sv
// EX/MEM and MEM/WB pipeline registers with memory access, stall
// generation, load-use detection, forwarding taps and write-back muxing.
module wb_pipe_regs (
    input  logic                  clk,
    input  logic                  rst,
    // EX stage entry
    input  logic                  ex_valid,
    input  logic [15:0]           ex_pc_wb_data,
    input  logic [15:0]           ex_ih_wb_data,
    input  logic [15:0]           ex_alu_answer,
    input  logic [15:0]           ex_mem_wdata,
    input  logic [3:0]            ex_wb_addr,
    input  logic [2:0]            ex_reg_op,
    input  logic [2:0]            ex_wb_data_op,
    input  logic                  ex_mem_rd,
    input  logic                  ex_mem_wr,
    input  logic                  flush,
    // ID sources for load-use detection
    input  logic [3:0]            id_reg1_addr,
    input  logic [3:0]            id_reg2_addr,
    input  logic                  id_reg1_used,
    input  logic                  id_reg2_used,
    // Memory bus
    wb_pipe_regs_if.master        mem,
    // EX/MEM forwarding taps
    output logic [15:0]           emo_pc_wb_data,
    output logic [15:0]           emo_ih_wb_data,
    output logic [15:0]           emo_alu_answer,
    output logic [3:0]            emo_wb_addr,
    output logic [2:0]            emo_reg_op,
    output logic [2:0]            emo_wb_data_op,
    // MEM/WB forwarding taps
    output logic [15:0]           mwo_pc_wb_data,
    output logic [15:0]           mwo_ih_wb_data,
    output logic [15:0]           mwo_alu_answer,
    output logic [15:0]           mwo_ram_read_answer,
    output logic [3:0]            mwo_wb_addr,
    output logic [2:0]            mwo_reg_op,
    output logic [2:0]            mwo_wb_data_op,
    // Control and write-back
    output logic                  stall_ex,
    output logic                  load_use_stall,
    output logic                  wb_en,
    output logic [3:0]            wb_addr,
    output logic [15:0]           wb_data,
    output logic [7:0]            mem_wait_cycles
);

    localparam logic [2:0] REG_NOP = 3'b000;
    localparam logic [2:0] WBD_NOP = 3'b000;
    localparam logic [2:0] WBD_ALU = 3'b001;
    localparam logic [2:0] WBD_MEM = 3'b010;
    localparam logic [2:0] WBD_IH  = 3'b011;
    localparam logic [2:0] WBD_PC  = 3'b100;

    // All-zero value of either struct is a bubble (NOP encodings, no access)
    typedef struct packed {
        logic        valid;
        logic [15:0] pc;
        logic [15:0] ih;
        logic [15:0] alu;
        logic [15:0] wdata;
        logic [3:0]  wb_addr;
        logic [2:0]  reg_op;
        logic [2:0]  wb_op;
        logic        rd;
        logic        wr;
    } em_t;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] ih;
        logic [15:0] alu;
        logic [15:0] ram;
        logic [3:0]  wb_addr;
        logic [2:0]  reg_op;
        logic [2:0]  wb_op;
    } mw_t;

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    em_t         r_em;
    mw_t         r_mw;
    state_t      r_state;
    logic [7:0]  r_wait_cnt;
    logic        w_mem_req;
    logic        w_stall;
    logic [15:0] w_wb_data;

    assign w_mem_req = r_em.valid & (r_em.rd | r_em.wr);
    assign w_stall   = w_mem_req & ~mem.mem_ack;

    // Memory request comes straight from EX/MEM, which is frozen while
    // stalled, so address/data stay steady for the whole wait
    assign mem.mem_req   = w_mem_req;
    assign mem.mem_we    = r_em.wr;
    assign mem.mem_addr  = r_em.alu;
    assign mem.mem_wdata = r_em.wdata;

    // EX/MEM: take the EX entry (or a bubble) unless stalled; flush only
    // acts on edges that actually load
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_em <= '0;
        end else if (!w_stall) begin
            if (flush || !ex_valid) begin
                r_em <= '0;
            end else begin
                r_em.valid   <= 1'b1;
                r_em.pc      <= ex_pc_wb_data;
                r_em.ih      <= ex_ih_wb_data;
                r_em.alu     <= ex_alu_answer;
                r_em.wdata   <= ex_mem_wdata;
                r_em.wb_addr <= ex_wb_addr;
                r_em.reg_op  <= ex_reg_op;
                r_em.wb_op   <= ex_wb_data_op;
                r_em.rd      <= ex_mem_rd;
                r_em.wr      <= ex_mem_wr;
            end
        end
    end

    // MEM/WB: bubble while waiting on memory, otherwise advance EX/MEM
    // and capture load data on the acknowledging cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mw <= '0;
        end else if (w_stall) begin
            r_mw <= '0;
        end else begin
            r_mw.pc      <= r_em.pc;
            r_mw.ih      <= r_em.ih;
            r_mw.alu     <= r_em.alu;
            r_mw.ram     <= (r_em.valid && r_em.rd) ? mem.mem_rdata : 16'h0000;
            r_mw.wb_addr <= r_em.wb_addr;
            r_mw.reg_op  <= r_em.reg_op;
            r_mw.wb_op   <= r_em.wb_op;
        end
    end

    // Request tracker: counter clears on a request's first cycle and
    // counts every cycle spent in WAIT, saturating at 255
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_mem_req) begin
                        r_wait_cnt <= 8'd0;
                        if (!mem.mem_ack) begin
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_wait_cnt != 8'hFF) begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                    if (mem.mem_ack) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Write-back data select by the MEM/WB source code
    always_comb begin
        w_wb_data = 16'h0000;
        case (r_mw.wb_op)
            WBD_ALU: w_wb_data = r_mw.alu;
            WBD_MEM: w_wb_data = r_mw.ram;
            WBD_IH:  w_wb_data = r_mw.ih;
            WBD_PC:  w_wb_data = r_mw.pc;
            default: w_wb_data = 16'h0000;
        endcase
    end

    assign stall_ex        = w_stall;
    assign load_use_stall  = (r_em.wb_op == WBD_MEM) && (r_em.reg_op != REG_NOP) &&
                             ((id_reg1_used && (id_reg1_addr == r_em.wb_addr)) ||
                              (id_reg2_used && (id_reg2_addr == r_em.wb_addr)));
    assign mem_wait_cycles = r_wait_cnt;

    assign emo_pc_wb_data  = r_em.pc;
    assign emo_ih_wb_data  = r_em.ih;
    assign emo_alu_answer  = r_em.alu;
    assign emo_wb_addr     = r_em.wb_addr;
    assign emo_reg_op      = r_em.reg_op;
    assign emo_wb_data_op  = r_em.wb_op;

    assign mwo_pc_wb_data      = r_mw.pc;
    assign mwo_ih_wb_data      = r_mw.ih;
    assign mwo_alu_answer      = r_mw.alu;
    assign mwo_ram_read_answer = r_mw.ram;
    assign mwo_wb_addr         = r_mw.wb_addr;
    assign mwo_reg_op          = r_mw.reg_op;
    assign mwo_wb_data_op      = r_mw.wb_op;

    assign wb_en   = (r_mw.reg_op != REG_NOP);
    assign wb_addr = r_mw.wb_addr;
    assign wb_data = w_wb_data;

endmodule

// File: tb/tb_wb_pipe_regs.sv
// Directed bench for wb_pipe_regs: inputs change and outputs are sampled
// on the falling clock edge; the DUT acts on rising edges.
module tb_wb_pipe_regs;

    logic        clk;
    logic        rst;
    logic        ex_valid;
    logic [15:0] ex_pc_wb_data, ex_ih_wb_data, ex_alu_answer, ex_mem_wdata;
    logic [3:0]  ex_wb_addr;
    logic [2:0]  ex_reg_op, ex_wb_data_op;
    logic        ex_mem_rd, ex_mem_wr, flush;
    logic [3:0]  id_reg1_addr, id_reg2_addr;
    logic        id_reg1_used, id_reg2_used;
    logic [15:0] emo_pc_wb_data, emo_ih_wb_data, emo_alu_answer;
    logic [3:0]  emo_wb_addr;
    logic [2:0]  emo_reg_op, emo_wb_data_op;
    logic [15:0] mwo_pc_wb_data, mwo_ih_wb_data, mwo_alu_answer, mwo_ram_read_answer;
    logic [3:0]  mwo_wb_addr;
    logic [2:0]  mwo_reg_op, mwo_wb_data_op;
    logic        stall_ex, load_use_stall, wb_en;
    logic [3:0]  wb_addr;
    logic [15:0] wb_data;
    logic [7:0]  mem_wait_cycles;

    int checks;
    int failures;

    wb_pipe_regs_if mem_bus ();

    wb_pipe_regs dut (
        .clk                 (clk),
        .rst                 (rst),
        .ex_valid            (ex_valid),
        .ex_pc_wb_data       (ex_pc_wb_data),
        .ex_ih_wb_data       (ex_ih_wb_data),
        .ex_alu_answer       (ex_alu_answer),
        .ex_mem_wdata        (ex_mem_wdata),
        .ex_wb_addr          (ex_wb_addr),
        .ex_reg_op           (ex_reg_op),
        .ex_wb_data_op       (ex_wb_data_op),
        .ex_mem_rd           (ex_mem_rd),
        .ex_mem_wr           (ex_mem_wr),
        .flush               (flush),
        .id_reg1_addr        (id_reg1_addr),
        .id_reg2_addr        (id_reg2_addr),
        .id_reg1_used        (id_reg1_used),
        .id_reg2_used        (id_reg2_used),
        .mem                 (mem_bus),
        .emo_pc_wb_data      (emo_pc_wb_data),
        .emo_ih_wb_data      (emo_ih_wb_data),
        .emo_alu_answer      (emo_alu_answer),
        .emo_wb_addr         (emo_wb_addr),
        .emo_reg_op          (emo_reg_op),
        .emo_wb_data_op      (emo_wb_data_op),
        .mwo_pc_wb_data      (mwo_pc_wb_data),
        .mwo_ih_wb_data      (mwo_ih_wb_data),
        .mwo_alu_answer      (mwo_alu_answer),
        .mwo_ram_read_answer (mwo_ram_read_answer),
        .mwo_wb_addr         (mwo_wb_addr),
        .mwo_reg_op          (mwo_reg_op),
        .mwo_wb_data_op      (mwo_wb_data_op),
        .stall_ex            (stall_ex),
        .load_use_stall      (load_use_stall),
        .wb_en               (wb_en),
        .wb_addr             (wb_addr),
        .wb_data             (wb_data),
        .mem_wait_cycles     (mem_wait_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_ex();
        ex_valid = 1'b0; ex_pc_wb_data = 16'h0; ex_ih_wb_data = 16'h0;
        ex_alu_answer = 16'h0; ex_mem_wdata = 16'h0; ex_wb_addr = 4'h0;
        ex_reg_op = 3'd0; ex_wb_data_op = 3'd0; ex_mem_rd = 1'b0; ex_mem_wr = 1'b0;
        flush = 1'b0;
    endtask

    // Drive a load into EX: REG write-back from MEM
    task automatic drive_load(input logic [15:0] addr, input logic [3:0] rd_reg);
        clear_ex();
        ex_valid = 1'b1; ex_alu_answer = addr; ex_wb_addr = rd_reg;
        ex_reg_op = 3'd1; ex_wb_data_op = 3'd2; ex_mem_rd = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        clear_ex();
        id_reg1_addr = 4'h0; id_reg2_addr = 4'h0; id_reg1_used = 1'b0; id_reg2_used = 1'b0;
        mem_bus.mem_ack = 1'b0; mem_bus.mem_rdata = 16'h0;
        repeat (2) @(negedge clk);
        checks++; if (emo_reg_op !== 3'd0) begin failures++; $display("FAIL rst_emo_reg_op got=%h exp=0", emo_reg_op); end
        checks++; if (wb_en !== 1'b0) begin failures++; $display("FAIL rst_wb_en got=%b exp=0", wb_en); end
        checks++; if (mem_bus.mem_req !== 1'b0) begin failures++; $display("FAIL rst_mem_req got=%b exp=0", mem_bus.mem_req); end
        checks++; if (mem_wait_cycles !== 8'd0) begin failures++; $display("FAIL rst_wait_cnt got=%0d exp=0", mem_wait_cycles); end
        rst = 1'b1;
        @(negedge clk);
        $display("tx reset released");
    endtask

    task automatic test_alu();
        clear_ex();
        ex_valid = 1'b1; ex_alu_answer = 16'h1234; ex_wb_addr = 4'd3;
        ex_reg_op = 3'd1; ex_wb_data_op = 3'd1;
        @(negedge clk);
        clear_ex();
        checks++; if (emo_alu_answer !== 16'h1234) begin failures++; $display("FAIL alu_emo_alu got=%h exp=1234", emo_alu_answer); end
        checks++; if (wb_en !== 1'b0) begin failures++; $display("FAIL alu_wb_en_early got=%b exp=0", wb_en); end
        @(negedge clk);
        checks++; if (wb_en !== 1'b1) begin failures++; $display("FAIL alu_wb_en got=%b exp=1", wb_en); end
        checks++; if (wb_addr !== 4'd3) begin failures++; $display("FAIL alu_wb_addr got=%h exp=3", wb_addr); end
        checks++; if (wb_data !== 16'h1234) begin failures++; $display("FAIL alu_wb_data got=%h exp=1234", wb_data); end
        @(negedge clk);
        checks++; if (wb_en !== 1'b0) begin failures++; $display("FAIL alu_wb_en_after got=%b exp=0", wb_en); end
        $display("tx alu r3<=1234 wb_data=%h", 16'h1234);
    endtask

    task automatic test_load_wait();
        drive_load(16'h8000, 4'd5);
        mem_bus.mem_ack = 1'b0;
        @(negedge clk);
        clear_ex();
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (stall_ex !== 1'b1) begin failures++; $display("FAIL ldw_stall[%0d] got=%b exp=1", i, stall_ex); end
            checks++; if (mem_bus.mem_addr !== 16'h8000) begin failures++; $display("FAIL ldw_addr[%0d] got=%h exp=8000", i, mem_bus.mem_addr); end
            checks++; if (wb_en !== 1'b0) begin failures++; $display("FAIL ldw_mw_bubble[%0d] got=%b exp=0", i, wb_en); end
            @(negedge clk);
        end
        mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 16'hBEEF;
        #1;
        checks++; if (stall_ex !== 1'b0) begin failures++; $display("FAIL ldw_stall_ack got=%b exp=0", stall_ex); end
        @(negedge clk);
        mem_bus.mem_ack = 1'b0; mem_bus.mem_rdata = 16'h0;
        checks++; if (mem_wait_cycles !== 8'd3) begin failures++; $display("FAIL ldw_wait_cnt got=%0d exp=3", mem_wait_cycles); end
        checks++; if (wb_data !== 16'hBEEF) begin failures++; $display("FAIL ldw_wb_data got=%h exp=beef", wb_data); end
        checks++; if (wb_addr !== 4'd5) begin failures++; $display("FAIL ldw_wb_addr got=%h exp=5", wb_addr); end
        checks++; if (mem_bus.mem_req !== 1'b0) begin failures++; $display("FAIL ldw_req_done got=%b exp=0", mem_bus.mem_req); end
        $display("tx load 8000 waits=3 data=beef");
    endtask

    task automatic test_load_use();
        drive_load(16'h0010, 4'd2);
        mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 16'h1111;
        @(negedge clk);
        clear_ex();
        id_reg1_addr = 4'd2; id_reg1_used = 1'b1;
        #1;
        checks++; if (load_use_stall !== 1'b1) begin failures++; $display("FAIL lu_r1_used got=%b exp=1", load_use_stall); end
        id_reg1_used = 1'b0;
        #1;
        checks++; if (load_use_stall !== 1'b0) begin failures++; $display("FAIL lu_r1_unused got=%b exp=0", load_use_stall); end
        id_reg2_addr = 4'd2; id_reg2_used = 1'b1;
        #1;
        checks++; if (load_use_stall !== 1'b1) begin failures++; $display("FAIL lu_r2_used got=%b exp=1", load_use_stall); end
        id_reg2_addr = 4'd3;
        #1;
        checks++; if (load_use_stall !== 1'b0) begin failures++; $display("FAIL lu_r2_other got=%b exp=0", load_use_stall); end
        @(negedge clk);
        mem_bus.mem_ack = 1'b0; mem_bus.mem_rdata = 16'h0;
        id_reg1_addr = 4'd0; id_reg2_addr = 4'd0; id_reg2_used = 1'b0;
        checks++; if (wb_data !== 16'h1111) begin failures++; $display("FAIL lu_wb_data got=%h exp=1111", wb_data); end
        checks++; if (wb_addr !== 4'd2) begin failures++; $display("FAIL lu_wb_addr got=%h exp=2", wb_addr); end
        $display("tx load-use r2 zero-wait data=1111");
    endtask

    task automatic test_flush();
        clear_ex();
        ex_valid = 1'b1; ex_alu_answer = 16'h5555; ex_wb_addr = 4'd7;
        ex_reg_op = 3'd1; ex_wb_data_op = 3'd1; flush = 1'b1;
        @(negedge clk);
        clear_ex();
        checks++; if (emo_reg_op !== 3'd0) begin failures++; $display("FAIL fl_emo_reg_op got=%h exp=0", emo_reg_op); end
        checks++; if (emo_alu_answer !== 16'h0) begin failures++; $display("FAIL fl_emo_alu got=%h exp=0", emo_alu_answer); end
        @(negedge clk);
        checks++; if (wb_en !== 1'b0) begin failures++; $display("FAIL fl_wb_en got=%b exp=0", wb_en); end
        // flush while stalled must leave EX/MEM untouched
        drive_load(16'h4000, 4'd4);
        @(negedge clk);
        clear_ex();
        ex_valid = 1'b1; ex_alu_answer = 16'h6666; ex_wb_addr = 4'd9;
        ex_reg_op = 3'd1; ex_wb_data_op = 3'd1; flush = 1'b1;
        @(negedge clk);
        checks++; if (emo_alu_answer !== 16'h4000) begin failures++; $display("FAIL fls_emo_alu got=%h exp=4000", emo_alu_answer); end
        checks++; if (emo_wb_addr !== 4'd4) begin failures++; $display("FAIL fls_emo_addr got=%h exp=4", emo_wb_addr); end
        checks++; if (emo_wb_data_op !== 3'd2) begin failures++; $display("FAIL fls_emo_op got=%h exp=2", emo_wb_data_op); end
        clear_ex();
        mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 16'h2222;
        @(negedge clk);
        mem_bus.mem_ack = 1'b0; mem_bus.mem_rdata = 16'h0;
        checks++; if (wb_data !== 16'h2222) begin failures++; $display("FAIL fls_wb_data got=%h exp=2222", wb_data); end
        checks++; if (emo_reg_op !== 3'd0) begin failures++; $display("FAIL fls_emo_after got=%h exp=0", emo_reg_op); end
        $display("tx flush bubble and flush-under-stall");
    endtask

    task automatic test_store();
        clear_ex();
        ex_valid = 1'b1; ex_mem_wr = 1'b1; ex_alu_answer = 16'h0100; ex_mem_wdata = 16'hCAFE;
        mem_bus.mem_ack = 1'b1;
        @(negedge clk);
        clear_ex();
        #1;
        checks++; if (mem_bus.mem_we !== 1'b1) begin failures++; $display("FAIL st_we got=%b exp=1", mem_bus.mem_we); end
        checks++; if (mem_bus.mem_wdata !== 16'hCAFE) begin failures++; $display("FAIL st_wdata got=%h exp=cafe", mem_bus.mem_wdata); end
        checks++; if (mem_bus.mem_addr !== 16'h0100) begin failures++; $display("FAIL st_addr got=%h exp=0100", mem_bus.mem_addr); end
        checks++; if (stall_ex !== 1'b0) begin failures++; $display("FAIL st_stall got=%b exp=0", stall_ex); end
        @(negedge clk);
        mem_bus.mem_ack = 1'b0;
        checks++; if (mem_bus.mem_we !== 1'b0) begin failures++; $display("FAIL st_we_after got=%b exp=0", mem_bus.mem_we); end
        checks++; if (wb_en !== 1'b0) begin failures++; $display("FAIL st_wb_en got=%b exp=0", wb_en); end
        checks++; if (mem_wait_cycles !== 8'd0) begin failures++; $display("FAIL st_wait_cnt got=%0d exp=0", mem_wait_cycles); end
        $display("tx store 0100<=cafe zero-wait");
    endtask

    task automatic test_saturate();
        drive_load(16'h0200, 4'd6);
        mem_bus.mem_ack = 1'b0;
        @(negedge clk);
        clear_ex();
        repeat (300) @(negedge clk);
        checks++; if (mem_wait_cycles !== 8'd255) begin failures++; $display("FAIL sat_wait_cnt got=%0d exp=255", mem_wait_cycles); end
        mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 16'h0A0A;
        @(negedge clk);
        mem_bus.mem_ack = 1'b0; mem_bus.mem_rdata = 16'h0;
        checks++; if (mem_wait_cycles !== 8'd255) begin failures++; $display("FAIL sat_wait_hold got=%0d exp=255", mem_wait_cycles); end
        checks++; if (wb_data !== 16'h0A0A) begin failures++; $display("FAIL sat_wb_data got=%h exp=0a0a", wb_data); end
        $display("tx long load saturates wait counter");
    endtask

    task automatic test_reset_mid_wait();
        drive_load(16'h3000, 4'd8);
        mem_bus.mem_ack = 1'b0;
        @(negedge clk);
        clear_ex();
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (mem_bus.mem_req !== 1'b0) begin failures++; $display("FAIL rmw_req got=%b exp=0", mem_bus.mem_req); end
        checks++; if (stall_ex !== 1'b0) begin failures++; $display("FAIL rmw_stall got=%b exp=0", stall_ex); end
        checks++; if (emo_alu_answer !== 16'h0) begin failures++; $display("FAIL rmw_emo_alu got=%h exp=0", emo_alu_answer); end
        checks++; if (mem_wait_cycles !== 8'd0) begin failures++; $display("FAIL rmw_wait_cnt got=%0d exp=0", mem_wait_cycles); end
        @(negedge clk);
        rst = 1'b1;
        mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 16'h7777;
        @(negedge clk);
        mem_bus.mem_ack = 1'b0; mem_bus.mem_rdata = 16'h0;
        checks++; if (wb_en !== 1'b0) begin failures++; $display("FAIL rmw_late_ack_wb got=%b exp=0", wb_en); end
        checks++; if (wb_data !== 16'h0) begin failures++; $display("FAIL rmw_late_ack_data got=%h exp=0", wb_data); end
        checks++; if (mem_wait_cycles !== 8'd0) begin failures++; $display("FAIL rmw_late_ack_cnt got=%0d exp=0", mem_wait_cycles); end
        $display("tx reset during wait, stray ack ignored");
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_alu();
        test_load_wait();
        test_load_use();
        test_flush();
        test_store();
        test_saturate();
        test_reset_mid_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
